fifo_stream_reader: RTL

Read-side engine for the BRAM-backed synchronous FIFO. It issues read enables into the FIFO and absorbs the BRAM's 1-cycle registered read latency in a 2-entry output buffer. It presents the data as a first-word-fall-through valid/ready stream (m_valid/m_ready/m_data). It sits between the FIFO's read port and any downstream consumer, and sustains one word per cycle when the FIFO is non-empty and m_ready is held high.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_skid_buf.sv | 79 +++++++
 rtl/fifo_stream_reader.sv | 51 +++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the BRAM-backed FIFO family: buffer occupancy states,
// skid depth and a level-width helper.
package fifo_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // Bits needed to count 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int LEVEL_W = level_width(BUF_DEPTH);

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer with head/tail pointers and a count FSM; presents
// its head word on a registered data output that holds while empty.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic [DWIDTH-1:0]  push_data,
    input  logic               pop,
    output logic               valid,
    output logic [DWIDTH-1:0]  data,
    output logic [LEVEL_W-1:0] level
);

    buf_state_t        state, state_next;
    logic              head, tail, head_next;
    logic [DWIDTH-1:0] slot      [BUF_DEPTH];
    logic [DWIDTH-1:0] slot_next [BUF_DEPTH];
    logic [DWIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY:   if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = TWO;
                else if (!push && pop) state_next = EMPTY;
            end
            TWO:     if (pop && !push) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: blocking assignments here so the indexed write is visible to the read below; registers use <=.
    always_comb begin
        slot_next = slot;
        if (push) slot_next[tail] = push_data;
        head_next = head ^ pop;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head   <= 1'b0;
            tail   <= 1'b0;
            data_q <= '0;
        end else begin
            head <= head_next;
            tail <= tail ^ push;
            // Track the next head word; hold the last delivered value once empty.
            if (state_next != EMPTY) data_q <= slot_next[head_next];
        end
    end

    // NOTE: slot storage is deliberately not reset; its contents are only observed after a push.
    always_ff @(posedge clk) begin
        slot <= slot_next;
    end

    assign valid = (state != EMPTY);
    assign data  = data_q;
    assign level = LEVEL_W'(state);

    // The credit logic upstream never issues a read whose return finds no room.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(state == TWO && push && !pop));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the BRAM FIFO: issues reads against buffer credit and
// hides the one-cycle read latency behind a two-entry skid buffer.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [1:0]        buf_level
);

    logic       inflight;
    logic       pop;
    logic [2:0] occ;
    logic [2:0] occ_after_pop;

    assign pop           = m_valid & m_ready;
    assign occ           = {1'b0, buf_level} + {2'b0, inflight};
    assign occ_after_pop = occ - {2'b0, pop};
    // A read is only issued when its return is guaranteed a free slot.
    assign fifo_rd_en    = rstn & ~fifo_empty & (occ_after_pop < 3'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    fifo_skid_buf #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (pop),
        .valid     (m_valid),
        .data      (m_data),
        .level     (buf_level)
    );

endmodule
